bus_invert_decoder: RTL and testbench

Receive-side end of the bus-invert link. Recovers each data word from the transmitted bus value and its invert line (data = bus XOR inv). Checks that every transfer obeys the bus-invert transition limit. Buffers decoded words in a 2-entry queue behind a valid/ready handshake. Sits between the bus-invert encoder link and the consumer datapath.

---
 rtl/bi_pkg.sv | 19 +
 rtl/bus_invert_decoder_if.sv | 22 ++
 rtl/bi_fifo2.sv | 60 ++++++
 rtl/bus_invert_decoder.sv | 71 +++++++
 tb/tb_bus_invert_decoder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bi_pkg.sv
// Shared bus-invert definitions used by both the encoder and the decoder ends of the link.
package bi_pkg;

    localparam int unsigned BI_WIDTH_DEFAULT = 8;
    // Widest bus popcount() accepts; narrower callers zero-extend.
    localparam int unsigned BI_MAX_W = 256;

    typedef enum logic [1:0] {Q_EMPTY, Q_ONE, Q_FULL} q_cnt_e;

    function automatic int unsigned popcount(input logic [BI_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < BI_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bus_invert_decoder_if.sv
// Valid/ready link between the bus-invert wire side and the decoded-word consumer.
interface bus_invert_decoder_if #(
    parameter int unsigned WIDTH = bi_pkg::BI_WIDTH_DEFAULT
);
    logic             in_valid;
    logic [WIDTH-1:0] in_bus;
    logic             in_inv;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_bus, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_bus, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bi_fifo2.sv
// Two-entry FIFO; head is always held in head_q so dout is a plain register output.
module bi_fifo2
    import bi_pkg::*;
#(
    parameter int unsigned WIDTH = BI_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    q_cnt_e           cnt_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= Q_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            unique case (cnt_q)
                Q_EMPTY: begin
                    if (push) begin
                        head_q <= din;
                        cnt_q  <= Q_ONE;
                    end
                end
                Q_ONE: begin
                    if (push && pop) begin
                        head_q <= din;
                    end else if (push) begin
                        tail_q <= din;
                        cnt_q  <= Q_FULL;
                    end else if (pop) begin
                        cnt_q <= Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    // Push is refused while full, so only a pop can move us.
                    if (pop) begin
                        head_q <= tail_q;
                        cnt_q  <= Q_ONE;
                    end
                end
                default: cnt_q <= Q_EMPTY;
            endcase
        end
    end

    assign dout  = head_q;
    assign full  = (cnt_q == Q_FULL);
    assign empty = (cnt_q == Q_EMPTY);

endmodule

// File: rtl/bus_invert_decoder.sv
// Receive end of the bus-invert link: decodes words, checks the transition limit on the raw
// bus, counts violations and buffers decoded words in a 2-entry queue.
module bus_invert_decoder
    import bi_pkg::*;
#(
    parameter int unsigned WIDTH = BI_WIDTH_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    bus_invert_decoder_if.slave link,
    output logic                viol_pulse,
    output logic [CNT_W-1:0]    viol_count
);

    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    logic             viol;
    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] prev_bus_q;
    logic             viol_pulse_q;
    logic [CNT_W-1:0] viol_count_q;
    int unsigned      hd;

    // Both handshake sides depend only on registered queue state.
    assign link.in_ready  = !full;
    assign link.out_valid = !empty;
    assign accept         = link.in_valid && !full;
    assign pop            = link.out_ready && !empty;

    assign decoded = link.in_bus ^ {WIDTH{link.in_inv}};

    // Transitions are measured on the wire value; the invert line is excluded.
    assign hd   = popcount(BI_MAX_W'(link.in_bus ^ prev_bus_q));
    assign viol = (hd > WIDTH / 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_bus_q   <= '0;
            viol_pulse_q <= 1'b0;
            viol_count_q <= '0;
        end else begin
            viol_pulse_q <= accept && viol;
            if (accept) begin
                prev_bus_q <= link.in_bus;
                if (viol && (viol_count_q != {CNT_W{1'b1}})) begin
                    viol_count_q <= viol_count_q + 1'b1;
                end
            end
        end
    end

    bi_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (decoded),
        .pop   (pop),
        .dout  (link.out_data),
        .full  (full),
        .empty (empty)
    );

    assign viol_pulse = viol_pulse_q;
    assign viol_count = viol_count_q;

endmodule

// File: tb/tb_bus_invert_decoder.sv
// Scoreboard bench for bus_invert_decoder: a queue-level model tracks expected words and
// violations; a negedge monitor compares every DUT output each cycle.
module tb_bus_invert_decoder;

    logic clk;
    logic rst;
    logic viol_pulse;
    logic [15:0] viol_count;
    logic viol_pulse2;
    logic [1:0] viol_count2;

    int checks;
    int errors;

    bus_invert_decoder_if #(.WIDTH(8)) bus ();
    bus_invert_decoder_if #(.WIDTH(8)) bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_bus    = bus.in_bus;
    assign bus2.in_inv    = bus.in_inv;
    assign bus2.out_ready = bus.out_ready;

    bus_invert_decoder #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .link       (bus.slave),
        .viol_pulse (viol_pulse),
        .viol_count (viol_count)
    );

    // Narrow-counter instance sees identical stimulus to exercise saturation.
    bus_invert_decoder #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .link       (bus2.slave),
        .viol_pulse (viol_pulse2),
        .viol_count (viol_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of decoded words, last wire value, violation tally.
    logic [7:0]  m_q[$];
    logic [7:0]  m_prev;
    logic        m_pulse;
    int unsigned m_viols;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_prev  = 8'h00;
            m_pulse = 1'b0;
            m_viols = 0;
        end else begin
            logic can_take;
            can_take = (m_q.size() < 2);
            m_pulse  = 1'b0;
            if (bus.out_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (bus.in_valid && can_take) begin
                m_q.push_back(bus.in_bus ^ {8{bus.in_inv}});
                if ($countones(bus.in_bus ^ m_prev) > 4) begin
                    m_pulse = 1'b1;
                    m_viols++;
                end
                m_prev = bus.in_bus;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            check("in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
            if (m_q.size() != 0) check("out_data", 32'(bus.out_data), 32'(m_q[0]));
            check("viol_pulse", 32'(viol_pulse), 32'(m_pulse));
            check("viol_count", 32'(viol_count), (m_viols > 65535) ? 32'd65535 : m_viols);
            check("viol_count_sat", 32'(viol_count2), (m_viols > 3) ? 32'd3 : m_viols);
        end
    end

    // All tasks start and end at posedge+2.
    task automatic send(input logic [7:0] b, input logic inv);
        logic r;
        bus.in_valid = 1'b1;
        bus.in_bus   = b;
        bus.in_inv   = inv;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #2;
            if (r) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd1, 32'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bus    = 8'h00;
        bus.in_inv    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("init_in_ready", 32'(bus.in_ready), 32'd1);
        check("init_out_valid", 32'(bus.out_valid), 32'd0);
        check("init_viol_count", 32'(viol_count), 32'd0);

        // Basic stream, including an inverted word.
        bus.out_ready = 1'b1;
        send(8'h0F, 1'b0);
        send(8'h0F, 1'b1);
        idle(3);

        // Tie from zero is legal; then one over the limit from zero violates.
        do_reset();
        bus.out_ready = 1'b1;
        send(8'h0F, 1'b0);
        idle(2);
        do_reset();
        bus.out_ready = 1'b1;
        send(8'h1F, 1'b0);
        idle(2);

        // Backpressure: A, B fill the queue, C waits for the first pop.
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'hA5, 1'b0);
                send(8'h5A, 1'b1);
                send(8'h3C, 1'b0);
            end
            begin
                idle(6);
                bus.out_ready = 1'b1;
            end
        join
        idle(4);

        // Five back-to-back full-swing words drive the 2-bit counter into saturation.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 8'hFF : 8'h00, 1'b0);
        idle(2);

        // Reset with a full queue, then the next word is judged against zero.
        bus.out_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        do_reset();
        bus.out_ready = 1'b1;
        send(8'h1F, 1'b1);
        idle(2);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_bus    = 8'($urandom);
            bus.in_inv    = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            idle(1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
